// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue with enqueue-time pre-decode.
// Head entry is read combinationally from registered storage.
module decode_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      instruction_F,
  input  logic [31:0]      pc_plus_four_F,
  input  logic             stall_D,
  input  logic             flush,
  output logic             valid_D,
  output logic [31:0]      instruction_D,
  output logic [31:0]      pc_plus_four_D,
  output logic             BranchD_pre,
  output logic             MfOpD_pre,
  output logic             HasDivD_pre,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   L_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] L_ONE  = PTR_W'(1);

  logic [31:0]      r_instr [DEPTH];
  logic [31:0]      r_pc4   [DEPTH];
  logic [2:0]       r_pre   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_valid;
  logic             w_enq;
  logic             w_deq;
  logic [2:0]       w_pre_f;

  function automatic logic [2:0] predec(input logic [31:0] w);
    logic [5:0] opc;
    logic [5:0] fn;
    logic       br;
    logic       mf;
    logic       dv;
    opc = w[31:26];
    fn  = w[5:0];
    br  = (opc != 6'd0 && opc <= 6'd7)
       || (opc == 6'd0 && (fn == 6'b001000 || fn == 6'b001001));
    mf  = opc == 6'd0 && (fn == 6'b010000 || fn == 6'b010010);
    dv  = opc == 6'd0 && fn[5:2] == 4'b0110;
    return {br, mf, dv};
  endfunction

  assign w_valid     = r_count != '0;
  assign fetch_ready = (r_count != L_FULL) && !flush;
  assign w_enq       = fetch_valid && fetch_ready;
  assign w_deq       = w_valid && !stall_D && !flush;
  assign w_pre_f     = predec(instruction_F);

  assign valid_D        = w_valid;
  assign count          = r_count;
  assign instruction_D  = w_valid ? r_instr[r_head] : NOP_WORD;
  assign pc_plus_four_D = w_valid ? r_pc4[r_head] : 32'h0;
  assign BranchD_pre    = w_valid && r_pre[r_head][2];
  assign MfOpD_pre      = w_valid && r_pre[r_head][1];
  assign HasDivD_pre    = w_valid && r_pre[r_head][0];

  // Entry payload needs no reset; validity lives in r_count.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_instr[r_tail] <= instruction_F;
      r_pc4[r_tail]   <= pc_plus_four_F;
      r_pre[r_tail]   <= w_pre_f;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + L_ONE;
      if (w_deq) r_head <= r_head + L_ONE;
      unique case (1'b1)
        w_enq && !w_deq: r_count <= r_count + 1'b1;
        w_deq && !w_enq: r_count <= r_count - 1'b1;
        default:         r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised instruction buffer between the fetch and decode stages; replaces the single fetch/decode pipeline register.
- Holds up to DEPTH fetched instructions with their pc_plus_four and presents the oldest one to decode.
- Pre-decodes branch, MFHI/MFLO and divide/multiply class bits at enqueue time, so the hazard unit sees them with no extra decode delay.
- Supports a fetch-side ready/valid handshake, a decode-side stall from the hazard unit, and a whole-queue flush on a taken branch or jump.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).
- NOP_WORD, 32'h00000000, instruction value driven on instruction_D when the queue is empty.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- fetch_valid  input  1  fetch offers instruction_F/pc_plus_four_F this cycle
- fetch_ready  output  1  queue accepts an entry this cycle
- instruction_F  input  32  fetched instruction
- pc_plus_four_F  input  32  PC+4 of the fetched instruction
- stall_D  input  1  hazard unit holds decode; head is not consumed
- flush  input  1  taken branch/jump (pc_src); discard all entries
- valid_D  output  1  head entry is valid
- instruction_D  output  32  head instruction, or NOP_WORD when empty
- pc_plus_four_D  output  32  head PC+4, or 0 when empty
- BranchD_pre  output  1  head is a branch or jump
- MfOpD_pre  output  1  head is MFHI or MFLO
- HasDivD_pre  output  1  head is MULT, MULTU, DIV or DIVU
- count  output  PTR_W+1  number of valid entries, 0..DEPTH

Behaviour:
- Storage and pointers:
  - Circular buffer with head and tail pointers of PTR_W bits that wrap modulo DEPTH.
  - Each entry stores the instruction, pc_plus_four and the three pre-decode bits.
- Reset (synchronous, on a clock edge with reset=1):
  - head=0, tail=0, count=0.
  - Outputs become valid_D=0, instruction_D=NOP_WORD, pc_plus_four_D=0, all pre-decode bits 0, fetch_ready=1.
  - Reset asserted mid-operation discards all entries; entry contents need no clearing.
- Fetch side:
  - fetch_ready = (count != DEPTH) and not flush; it is combinational.
  - enq = fetch_valid and fetch_ready.
  - A full queue does not accept in the same cycle as a dequeue (no pass-through when full).
- Decode side:
  - deq = valid_D and not stall_D and not flush.
  - The head outputs are a combinational read of the registered head entry, so an enqueue into an empty queue appears at decode one cycle later. That is the same latency as the former pipeline register.
- count update:
  - count_next = count + enq - deq.
  - Simultaneous enq and deq leaves count unchanged and advances both pointers.
- Flush:
  - On an edge with flush=1: head=tail=0 and count=0, whatever stall_D and fetch_valid are.
  - Priority is reset > flush > stall.
- Empty queue:
  - valid_D=0, and deq is impossible.
  - stall_D has no effect.
- Pre-decode (opcode = instruction_F[31:26], funct = instruction_F[5:0]):
  - BranchD_pre = opcode in {000001, 000010, 000011, 000100, 000101, 000110, 000111}, or (opcode=000000 and funct in {001000, 001001}).
  - MfOpD_pre = opcode=000000 and funct in {010000, 010010}.
  - HasDivD_pre = opcode=000000 and funct in {011000, 011001, 011010, 011011}.
  - All three bits are 0 when valid_D=0.
- Hazard/timing:
  - No combinational path from stall_D or flush to instruction_D.
  - flush and stall_D feed only fetch_ready, the internal enq/deq, and the register updates.

Test Plan:
- Reset, then fetch_valid=1 with instruction 0x00851020 (add), pc_plus_four=0x00400004, stall_D=0 → after 1 edge valid_D=1, instruction_D=0x00851020, pc_plus_four_D=0x00400004, all pre bits 0, count=1.
- DEPTH=4, stall_D=1, enqueue 5 consecutive words 0x1..0x5 → count reaches 4, fetch_ready=0 on the 5th cycle, word 0x5 not taken. Release the stall → head outputs 0x1, 0x2, 0x3, 0x4 in order, then valid_D=0 and instruction_D=0.
- Wrap-around: run 10 enqueue/dequeue pairs with no stall → output order matches input order across the pointer wrap, and count stays at 1.
- Pre-decode: enqueue 0x10220003 (beq) → BranchD_pre=1. Enqueue 0x00001010 (mfhi) → MfOpD_pre=1. Enqueue 0x0043001A (div) → HasDivD_pre=1. Enqueue 0x03E00008 (jr) → BranchD_pre=1.
- Flush with 3 entries queued, while fetch_valid=1 and stall_D=1 → fetch_ready=0 that cycle; after the edge count=0 and valid_D=0. The next fetch is accepted and appears at decode one cycle later.
- Reset asserted with a full queue and enq/deq active → next cycle count=0, valid_D=0, fetch_ready=1.
